mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
Iterative unsigned multiply/divide execution unit in the EX stage, directly upstream of the flags register. It accepts one operation per start handshake and runs a fixed-latency shift-add or restoring-divide loop. On completion it presents result_hi/result_lo plus zi/ni/ci and a one-cycle flags_en strobe. These wire straight to the flags register's zi, ni, ci and enable inputs.

Parameters:
WIDTH, 16, operand width in bits; results are WIDTH each (hi/lo); must be >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  1  0 = MUL (unsigned), 1 = DIV (unsigned)
a  input  WIDTH  multiplicand / dividend, sampled on accept
b  input  WIDTH  multiplier / divisor, sampled on accept
busy  output  1  high in BUSY and DONE states
done  output  1  one-cycle completion pulse
result_lo  output  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient
result_hi  output  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder
zi  output  1  zero flag to flags register
ni  output  1  negative flag (result_lo MSB)
ci  output  1  carry: MUL high half nonzero; DIV divide-by-zero
flags_en  output  1  flags load strobe, identical timing to done

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, counter=0, all outputs 0. Takes priority over every other event.
- States: IDLE -> BUSY on accepted start; BUSY -> DONE after WIDTH iterations; DONE -> IDLE unconditionally after 1 cycle.
- Accept: at edge with state=IDLE, start=1. Latch a, b, op; clear working regs; counter=0.
- BUSY: one iteration per edge, counter increments. WIDTH iterations occur at edges T+1..T+WIDTH (T = accept edge). The state becomes DONE at edge T+WIDTH.
- MUL: shift-add over latched b bits LSB first. Accumulator is 2*WIDTH+1 bits internally. No truncation of the product.
- DIV: restoring division, MSB first. The remainder register is WIDTH+1 bits for the trial subtract.
- Divide-by-zero takes no special path. Restoring algorithm yields quotient = all ones and remainder = a, at the same latency.
- DONE cycle: done=1, flags_en=1, busy=1; results and flags valid.
- Result and flags registers are written only at the BUSY->DONE edge. They hold their values until the next completion or reset.
- Flags:
  - MUL: zi = (product == 0); ni = result_lo[WIDTH-1]; ci = (result_hi != 0).
  - DIV: zi = (quotient == 0); ni = quotient[WIDTH-1]; ci = (b == 0).
- Latency: done high exactly WIDTH cycles after the accept edge, for exactly one cycle. Throughput is one op per WIDTH+2 cycles.
- start while busy=1 (BUSY or DONE) is ignored. Nothing is queued, and a/b/op changes have no effect on the running op.
- start held high continuously causes re-accept on the first IDLE cycle after DONE.
- Reset mid-BUSY aborts the op with no done/flags_en pulse. Outputs clear to 0.
- Reset in the DONE cycle clears done/flags_en on the next edge, as for normal exit.
- Never drive flags_en without done. Both are registered, not combinational from inputs.

Test Plan:
- WIDTH=16, MUL a=300 b=200 -> after 16 cycles: done=1, result_lo=0xEA60, result_hi=0x0000, zi=0, ni=1, ci=0, flags_en=1 for 1 cycle.
- MUL a=0xFFFF b=0xFFFF -> result_hi=0xFFFE, result_lo=0x0001, zi=0, ni=0, ci=1. Then MUL a=0 b=0x1234 -> all results 0, zi=1, ni=0, ci=0.
- DIV a=1000 b=7 -> result_lo=0x008E, result_hi=0x0006, zi=0, ni=0, ci=0. Then DIV a=5 b=9 -> quotient 0, remainder 5, zi=1.
- DIV a=0x1234 b=0 -> at same 16-cycle latency: result_lo=0xFFFF, result_hi=0x1234, ci=1, ni=1, zi=0.
- Accept MUL 3*4, pulse start with DIV operands at cycles 3 and DONE cycle -> the second start is ignored; result_lo=12, single done pulse. Hold start high -> next accept occurs on the IDLE cycle after DONE.
- Start MUL, assert rst for 1 cycle at iteration 5 -> no done/flags_en ever; busy=0 and all outputs 0 after the reset edge. A new op afterwards completes correctly.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply / restoring-divide unit with fixed WIDTH-cycle latency.
// Results and zi/ni/ci are registered at completion and accompanied by a one-cycle done/flags_en strobe.
module mul_div_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zi,
    output logic             ni,
    output logic             ci,
    output logic             flags_en
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic             op_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [2*WIDTH:0] work_reg, work_next;
    logic [WIDTH:0]   mul_upper, div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH-1:0] lo_reg, hi_reg;
    logic             zi_reg, ni_reg, ci_reg, done_reg;
    logic             accept, last_iter;

    assign accept    = (state_reg == IDLE) && start;
    assign last_iter = (state_reg == BUSY) && (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (cnt_reg == CW'(WIDTH - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg != IDLE);
        done     = done_reg;
        flags_en = done_reg;
    end

    // One working register serves both ops: MUL keeps {carry, hi, lo=multiplier},
    // DIV keeps {remainder(WIDTH+1), quotient/dividend(WIDTH)}.
    always_comb begin
        mul_upper = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + (work_reg[0] ? {1'b0, a_reg} : '0);
        div_shift = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_reg};
        if (!op_reg) begin
            work_next = {1'b0, mul_upper, work_reg[WIDTH-1:1]};
        end else if (!div_diff[WIDTH+1]) begin
            work_next = {div_diff[WIDTH:0], work_reg[WIDTH-2:0], 1'b1};
        end else begin
            work_next = {div_shift, work_reg[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            op_reg   <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            work_reg <= '0;
            lo_reg   <= '0;
            hi_reg   <= '0;
            zi_reg   <= 1'b0;
            ni_reg   <= 1'b0;
            ci_reg   <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= last_iter;
            if (accept) begin
                op_reg   <= op;
                a_reg    <= a;
                b_reg    <= b;
                work_reg <= {{(WIDTH + 1){1'b0}}, (op ? a : b)};
                cnt_reg  <= '0;
            end else if (state_reg == BUSY) begin
                work_reg <= work_next;
                cnt_reg  <= cnt_reg + CW'(1);
            end
            // Both ops leave the low half / high half in the same place, so one mapping suffices.
            if (last_iter) begin
                lo_reg <= work_next[WIDTH-1:0];
                hi_reg <= work_next[2*WIDTH-1:WIDTH];
                zi_reg <= op_reg ? (work_next[WIDTH-1:0] == '0) : (work_next[2*WIDTH-1:0] == '0);
                ni_reg <= work_next[WIDTH-1];
                ci_reg <= op_reg ? (b_reg == '0) : (work_next[2*WIDTH-1:WIDTH] != '0);
            end
        end
    end

    assign result_lo = lo_reg;
    assign result_hi = hi_reg;
    assign zi        = zi_reg;
    assign ni        = ni_reg;
    assign ci        = ci_reg;

endmodule
